// File: rtl/arb_requester.sv
// ----------------------------------------------------------------------------
// arb_requester
//
// Requesting agent for the two-agent request/grant arbiter. A burst command
// is taken on a valid/ready port. The block then raises req, waits for gnt and
// drives one data beat on every granted cycle. After the last beat it drops
// req and waits for the arbiter's (lagging) grant to fall before it accepts
// the next command.
//
// Optional feature macro: ARB_REQ_TIMEOUT_EN
//    When defined, the wait for the first grant is bounded by TIMEOUT cycles.
//    On expiry the command is dropped and err pulses for one cycle. When it is
//    undefined, the block waits for the grant indefinitely and err is tied 0.
//
// Parameters
//    BURST_W  width of cmd_len; a burst is cmd_len+1 beats (1..2^BURST_W)
//    DATA_W   bus data width
//    TIMEOUT  grant-wait limit in cycles (used only with ARB_REQ_TIMEOUT_EN)
//
// Ports
//    clk        in   clock, rising edge
//    rest_n     in   asynchronous active-low reset
//    cmd_valid  in   command offered
//    cmd_ready  out  high in IDLE; command taken when cmd_valid && cmd_ready
//    cmd_len    in   beats minus one
//    cmd_data   in   payload of the first beat; later beats add the beat index
//    req        out  request to the arbiter
//    gnt        in   grant from the arbiter
//    bus_valid  out  a beat is being driven
//    bus_data   out  beat payload
//    bus_last   out  final beat of the burst
//    done       out  one-cycle pulse when a burst has fully completed
//    err        out  one-cycle pulse on grant timeout
// ----------------------------------------------------------------------------
module arb_requester #(
   parameter int BURST_W = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rest_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [BURST_W-1:0] cmd_len,
   input  logic [DATA_W-1:0]  cmd_data,
   output logic               req,
   input  logic               gnt,
   output logic               bus_valid,
   output logic [DATA_W-1:0]  bus_data,
   output logic               bus_last,
   output logic               done,
   output logic               err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   // A zero or negative grant-wait limit has no meaning.
   if (TIMEOUT < 1) begin : g_timeout_check
      $error("arb_requester: TIMEOUT must be at least 1");
   end

   state_t             state;
   state_t             state_nxt;

   // Captured command: beat count limit and the payload of beat 0.
   logic [BURST_W-1:0] len_q;
   logic [BURST_W-1:0] len_nxt;
   logic [DATA_W-1:0]  base_q;
   logic [DATA_W-1:0]  base_nxt;

   // Index of the beat currently on the bus. It never has to pass len_q, so
   // BURST_W bits cover a full 2^BURST_W beat burst without wrapping.
   logic [BURST_W-1:0] count_q;
   logic [BURST_W-1:0] count_nxt;
   logic [BURST_W-1:0] count_inc;

   logic               req_nxt;
   logic               bus_valid_nxt;
   logic [DATA_W-1:0]  bus_data_nxt;
   logic               bus_last_nxt;
   logic               done_nxt;

`ifdef ARB_REQ_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   // Cycles spent in REQ without a grant, and a marker that the current
   // command was abandoned so the trip through RELEASE raises no done.
   logic [TW-1:0]      wait_q;
   logic [TW-1:0]      wait_nxt;
   logic               abort_q;
   logic               abort_nxt;
   logic               err_nxt;
`endif

   assign count_inc = count_q + BURST_W'(1);

   // The command port is open exactly while the agent is idle.
   assign cmd_ready = (state == IDLE);

   // Next-state and next-output decode. Every registered output is computed
   // here one cycle ahead, so req/bus_*/done all change on the clock edge.
   always_comb begin
      state_nxt     = state;
      len_nxt       = len_q;
      base_nxt      = base_q;
      count_nxt     = count_q;
      req_nxt       = req;
      bus_valid_nxt = bus_valid;
      bus_data_nxt  = bus_data;
      bus_last_nxt  = bus_last;
      done_nxt      = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_nxt      = wait_q;
      abort_nxt     = abort_q;
      err_nxt       = 1'b0;
`endif

      case (state)
         IDLE: begin
            // A grant seen here belongs to nobody we know about and is ignored.
            if (cmd_valid) begin
               len_nxt   = cmd_len;
               base_nxt  = cmd_data;
               count_nxt = '0;
               req_nxt   = 1'b1;
               state_nxt = REQ;
`ifdef ARB_REQ_TIMEOUT_EN
               wait_nxt  = '0;
               abort_nxt = 1'b0;
`endif
            end
         end

         REQ: begin
            if (gnt) begin
               // First beat goes out on the cycle after the grant is seen.
               bus_valid_nxt = 1'b1;
               bus_data_nxt  = base_q;
               bus_last_nxt  = (len_q == '0);
               state_nxt     = XFER;
            end
`ifdef ARB_REQ_TIMEOUT_EN
            else if (wait_q == TW'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th ungranted cycle: give up on the
               // command and let RELEASE wait out any late grant.
               req_nxt   = 1'b0;
               err_nxt   = 1'b1;
               abort_nxt = 1'b1;
               state_nxt = RELEASE;
            end
            else begin
               wait_nxt = wait_q + TW'(1);
            end
`endif
         end

         XFER: begin
            // A beat only counts when the arbiter grants in the same cycle;
            // otherwise the same beat stays on the bus and is retried.
            if (bus_valid && gnt) begin
               if (bus_last) begin
                  req_nxt       = 1'b0;
                  bus_valid_nxt = 1'b0;
                  bus_last_nxt  = 1'b0;
                  state_nxt     = RELEASE;
               end
               else begin
                  count_nxt    = count_inc;
                  bus_data_nxt = base_q + DATA_W'(count_inc);
                  bus_last_nxt = (count_inc == len_q);
               end
            end
         end

         RELEASE: begin
            // The arbiter's grant trails req by two cycles; only once it has
            // dropped is the bus really free for the other agent.
            if (!gnt) begin
               state_nxt = IDLE;
`ifdef ARB_REQ_TIMEOUT_EN
               done_nxt  = !abort_q;
`else
               done_nxt  = 1'b1;
`endif
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs. Reset throws away any command in flight.
   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         state     <= IDLE;
         len_q     <= '0;
         base_q    <= '0;
         count_q   <= '0;
         req       <= 1'b0;
         bus_valid <= 1'b0;
         bus_data  <= '0;
         bus_last  <= 1'b0;
         done      <= 1'b0;
      end
      else begin
         state     <= state_nxt;
         len_q     <= len_nxt;
         base_q    <= base_nxt;
         count_q   <= count_nxt;
         req       <= req_nxt;
         bus_valid <= bus_valid_nxt;
         bus_data  <= bus_data_nxt;
         bus_last  <= bus_last_nxt;
         done      <= done_nxt;
      end
   end

`ifdef ARB_REQ_TIMEOUT_EN
   // Grant-wait timer, abandon marker and the err pulse.
   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         wait_q  <= '0;
         abort_q <= 1'b0;
         err     <= 1'b0;
      end
      else begin
         wait_q  <= wait_nxt;
         abort_q <= abort_nxt;
         err     <= err_nxt;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// ----------------------------------------------------------------------------
// tb_arb_requester
//
// Two arb_requester agents share a behavioural two-agent arbiter whose grant
// trails req by two cycles. Agent 0 has TIMEOUT=8, agent 1 TIMEOUT=64.
// Directed sequences cover reset, a single burst, grant loss, contention,
// the grant timeout and reset during a transfer; a randomized phase then runs
// both agents against a scoreboard of expected beats.
// ----------------------------------------------------------------------------
module tb_arb_requester;

   localparam int BURST_W = 4;
   localparam int DATA_W  = 8;

   logic               clk = 1'b0;
   logic               rest_n = 1'b0;
   logic [1:0]         cmd_valid = '0;
   logic [BURST_W-1:0] cmd_len [2];
   logic [DATA_W-1:0]  cmd_data [2];
   logic [1:0]         gnt_mask = '0;
   logic [1:0]         arb_dec;
   logic [1:0]         arb_gnt;

   wire  [1:0]         cmd_ready;
   wire  [1:0]         req;
   wire  [1:0]         gnt;
   wire  [1:0]         bus_valid;
   wire  [1:0]         bus_last;
   wire  [1:0]         done;
   wire  [1:0]         err;
   wire  [DATA_W-1:0]  bus_data [2];

   int tests_run    = 0;
   int tests_failed = 0;
   int cycle_count  = 0;
   bit random_active = 1'b0;

   // The bench can pull an agent's grant low to model a lost grant.
   assign gnt = arb_gnt & ~gnt_mask;

   always #5 clk = ~clk;

   always @(posedge clk) cycle_count <= cycle_count + 1;

   arb_requester #(.BURST_W(BURST_W), .DATA_W(DATA_W), .TIMEOUT(8)) u_req0 (
      .clk(clk), .rest_n(rest_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_len(cmd_len[0]), .cmd_data(cmd_data[0]),
      .req(req[0]), .gnt(gnt[0]),
      .bus_valid(bus_valid[0]), .bus_data(bus_data[0]), .bus_last(bus_last[0]),
      .done(done[0]), .err(err[0])
   );

   arb_requester #(.BURST_W(BURST_W), .DATA_W(DATA_W), .TIMEOUT(64)) u_req1 (
      .clk(clk), .rest_n(rest_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_len(cmd_len[1]), .cmd_data(cmd_data[1]),
      .req(req[1]), .gnt(gnt[1]),
      .bus_valid(bus_valid[1]), .bus_data(bus_data[1]), .bus_last(bus_last[1]),
      .done(done[1]), .err(err[1])
   );

   // Arbiter model: one owner at a time, decision registered once and then
   // delayed once more, so gnt follows req by two cycles. A new owner is only
   // chosen once every grant line is low again, agent 0 winning ties.
   always @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         arb_dec <= '0;
         arb_gnt <= '0;
      end
      else begin
         arb_gnt <= arb_dec;
         if (arb_dec != 2'b00) begin
            if ((arb_dec & req) == 2'b00) arb_dec <= 2'b00;
         end
         else if (arb_gnt == 2'b00) begin
            if (req[0])      arb_dec <= 2'b01;
            else if (req[1]) arb_dec <= 2'b10;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)",
                  tag, observed, expected, cycle_count);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Offer one command on agent a and hold it until it is taken. Entered and
   // left 1 time unit after a rising edge; on return the bench is in the
   // first cycle after acceptance.
   task automatic applyStimulus(input int a, input logic [BURST_W-1:0] len,
                                input logic [DATA_W-1:0] data);
      bit accepted;
      accepted     = 1'b0;
      cmd_valid[a] = 1'b1;
      cmd_len[a]   = len;
      cmd_data[a]  = data;
      for (int i = 0; i < 300 && !accepted; i++) begin
         @(negedge clk);
         if (cmd_ready[a]) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid[a] = 1'b0;
      checkOutput("cmd_accepted", accepted, 1);
   endtask

   task automatic waitDone(input int a, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (done[a]) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      checkOutput("done_seen", seen, 1);
   endtask

   task automatic randomAgent(input int a, input int count);
      for (int n = 0; n < count; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         repeat (gap) nextCycle();
         applyStimulus(a, BURST_W'($urandom_range(0, 15)), DATA_W'($urandom_range(0, 255)));
      end
   endtask

   // Scoreboard per agent: an accepted command expands into its list of
   // beats {last, data}; each granted beat must match the head of the list,
   // and every completed burst entitles the agent to exactly one done.
   for (genvar g = 0; g < 2; g++) begin : mon
      logic [DATA_W:0] exp_q [$];
      int              pending = 0;

      always @(negedge clk) begin
         logic [DATA_W:0] e;
         if (!rest_n) begin
            exp_q.delete();
            pending = 0;
         end
         else begin
            if (cmd_valid[g] && cmd_ready[g]) begin
               for (int k = 0; k <= int'(cmd_len[g]); k++)
                  exp_q.push_back({(k == int'(cmd_len[g])), DATA_W'(int'(cmd_data[g]) + k)});
            end
            if (bus_valid[g] && gnt[g]) begin
               if (exp_q.size() == 0) begin
                  checkOutput("spurious_beat", bus_valid[g], 0);
               end
               else begin
                  e = exp_q.pop_front();
                  checkOutput("beat_data", bus_data[g], e[DATA_W-1:0]);
                  checkOutput("beat_last", bus_last[g], e[DATA_W]);
                  if (e[DATA_W]) pending++;
               end
            end
            if (done[g]) begin
               checkOutput("done_expected", pending > 0, 1);
               if (pending > 0) pending--;
            end
`ifdef ARB_REQ_TIMEOUT_EN
            if (err[g]) begin
               checkOutput("err_with_burst_waiting", exp_q.size() > 0, 1);
               exp_q.delete();
            end
`else
            checkOutput("err_tied_low", err[g], 0);
`endif
         end
      end
   end

   // The two agents must never drive beats at the same time.
   always @(negedge clk) begin
      if (rest_n) checkOutput("bus_overlap", bus_valid[0] & bus_valid[1], 0);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  first1;
      int  last0;
      int  done0k;
      int  done1k;
      bit  drained;
      int  exp_off;

      cmd_len[0]  = '0;
      cmd_len[1]  = '0;
      cmd_data[0] = '0;
      cmd_data[1] = '0;

      // Reset values while held in reset.
      repeat (3) nextCycle();
      checkOutput("rst_req", req, 0);
      checkOutput("rst_bus_valid", bus_valid, 0);
      checkOutput("rst_bus_last", bus_last, 0);
      checkOutput("rst_bus_data0", bus_data[0], 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_cmd_ready", cmd_ready, 2'b11);
      rest_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         nextCycle();
         checkOutput("idle_no_req", req, 0);
      end

      // Single burst: len 3 from 8'hFE, accepted in cycle T (k counts from T).
      applyStimulus(0, 4'd3, 8'hFE);
      for (int k = 1; k <= 12; k++) begin
         checkOutput("burst_req", req[0], (k <= 7));
         checkOutput("burst_valid", bus_valid[0], (k >= 4 && k <= 7));
         if (k >= 4 && k <= 7) checkOutput("burst_data", bus_data[0], DATA_W'(8'hFE + k - 4));
         checkOutput("burst_last", bus_last[0], (k == 7));
         checkOutput("burst_done", done[0], (k == 11));
         checkOutput("burst_cmd_ready", cmd_ready[0], (k >= 11));
         nextCycle();
      end

      // Grant loss for two cycles while beat 1 is on the bus.
      applyStimulus(0, 4'd3, 8'h10);
      for (int k = 1; k <= 10; k++) begin
         gnt_mask[0] = (k == 5 || k == 6);
         exp_off = (k <= 4) ? 0 : (k <= 7) ? 1 : k - 6;
         checkOutput("loss_req", req[0], (k <= 9));
         checkOutput("loss_valid", bus_valid[0], (k >= 4 && k <= 9));
         if (k >= 4 && k <= 9) checkOutput("loss_data", bus_data[0], DATA_W'(8'h10 + exp_off));
         checkOutput("loss_last", bus_last[0], (k == 9));
         nextCycle();
      end
      gnt_mask[0] = 1'b0;
      waitDone(0, 20);

      // Contention: both agents commanded in the same cycle.
      first1 = -1;
      last0  = -1;
      done0k = -1;
      done1k = -1;
      fork
         applyStimulus(0, 4'd1, 8'hA0);
         applyStimulus(1, 4'd1, 8'hB0);
      join
      for (int k = 1; k <= 40; k++) begin
         if (gnt[0]) last0 = k;
         if (gnt[1] && first1 < 0) first1 = k;
         if (done[0] && done0k < 0) done0k = k;
         if (done[1] && done1k < 0) done1k = k;
         nextCycle();
      end
      checkOutput("cont_done0_seen", done0k > 0, 1);
      checkOutput("cont_done1_seen", done1k > 0, 1);
      checkOutput("cont_agent0_first", done0k < done1k, 1);
      checkOutput("cont_gnt1_after_gnt0", first1 > last0, 1);

      // Grant never arrives.
      gnt_mask[0] = 1'b1;
`ifdef ARB_REQ_TIMEOUT_EN
      applyStimulus(0, 4'd2, 8'h55);
      for (int k = 1; k <= 12; k++) begin
         checkOutput("to_req", req[0], (k <= 8));
         checkOutput("to_err", err[0], (k == 9));
         checkOutput("to_no_done", done[0], 0);
         checkOutput("to_cmd_ready", cmd_ready[0], (k >= 10));
         nextCycle();
      end
      repeat (4) nextCycle();
      gnt_mask[0] = 1'b0;
`else
      applyStimulus(0, 4'd0, 8'h55);
      for (int k = 1; k <= 20; k++) begin
         checkOutput("wait_req_held", req[0], 1);
         checkOutput("wait_err_low", err[0], 0);
         checkOutput("wait_cmd_ready", cmd_ready[0], 0);
         nextCycle();
      end
      gnt_mask[0] = 1'b0;
      waitDone(0, 40);
`endif

      // Reset while beat 2 of a 4-beat burst is on the bus.
      nextCycle();
      applyStimulus(0, 4'd3, 8'h30);
      repeat (5) nextCycle();
      checkOutput("pre_rst_beat2", bus_data[0], 8'h32);
      rest_n = 1'b0;
      #1;
      checkOutput("mid_rst_req", req[0], 0);
      checkOutput("mid_rst_valid", bus_valid[0], 0);
      checkOutput("mid_rst_last", bus_last[0], 0);
      checkOutput("mid_rst_data", bus_data[0], 0);
      checkOutput("mid_rst_done", done[0], 0);
      checkOutput("mid_rst_cmd_ready", cmd_ready[0], 1);
      nextCycle();
      nextCycle();
      rest_n = 1'b1;
      nextCycle();
      applyStimulus(0, 4'd2, 8'h70);
      repeat (3) nextCycle();
      checkOutput("post_rst_first_valid", bus_valid[0], 1);
      checkOutput("post_rst_first_data", bus_data[0], 8'h70);
      waitDone(0, 30);

      // Randomized traffic on both agents with occasional grant loss.
      random_active = 1'b1;
      fork
         begin
            fork
               randomAgent(0, 25);
               randomAgent(1, 25);
            join
            random_active = 1'b0;
         end
         begin
            while (random_active) begin
               nextCycle();
               gnt_mask = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            end
            gnt_mask = '0;
         end
      join

      drained = 1'b0;
      for (int i = 0; i < 400 && !drained; i++) begin
         nextCycle();
         drained = (cmd_ready == 2'b11) && (mon[0].exp_q.size() == 0) &&
                   (mon[1].exp_q.size() == 0) && (mon[0].pending == 0) &&
                   (mon[1].pending == 0);
      end
      checkOutput("random_drained", drained, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
